apa102_rx_chain: RTL and testbench



---
 rtl/apa102_rx_chain_if.sv | 29 ++
 rtl/apa102_rx_chain.sv | 141 ++++++++++++++
 tb/tb_apa102_rx_chain.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/apa102_rx_chain_if.sv
`default_nettype none
// apa102_rx_chain_if: serial pins and frame outputs of the APA102 chain receiver.
// Rev 1.0
interface apa102_rx_chain_if #(
  parameter int NUM_LEDS        = 7,
  parameter int KEEP_BRIGHTNESS = 0
);
  localparam int BPL    = (KEEP_BRIGHTNESS != 0) ? 29 : 24;
  localparam int DATA_W = NUM_LEDS * BPL;

  logic              sck;
  logic              sda;
  logic [DATA_W-1:0] data_out;
  logic              frame_valid;
  logic              frame_error;
  logic              busy;
  logic [7:0]        frame_count;

  modport master (
    output sck, sda,
    input  data_out, frame_valid, frame_error, busy, frame_count
  );

  modport slave (
    input  sck, sda,
    output data_out, frame_valid, frame_error, busy, frame_count
  );
endinterface
`default_nettype wire

// File: rtl/apa102_rx_chain.sv
`default_nettype none
// apa102_rx_chain: oversampled APA102 receiver committing NUM_LEDS pixels atomically.
// Rev 1.0
module apa102_rx_chain #(
  parameter int NUM_LEDS        = 7,
  parameter int KEEP_BRIGHTNESS = 0,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  apa102_rx_chain_if.slave        bus
);
  localparam int BPL    = (KEEP_BRIGHTNESS != 0) ? 29 : 24;
  localparam int DATA_W = NUM_LEDS * BPL;
  localparam int IDLE_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [IDLE_W-1:0] IDLE_MAX       = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [5:0]        LAST_LED       = 6'(NUM_LEDS - 1);
  localparam logic [4:0]        FIRST_DATA_BIT = (KEEP_BRIGHTNESS != 0) ? 5'd3 : 5'd8;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LED  = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   prev_sck;
  logic [5:0]             zero_cnt;
  logic [4:0]             bit_idx;
  logic [5:0]             led_idx;
  logic [IDLE_W-1:0]      idle_cnt;
  logic [DATA_W-1:0]      shadow;
  logic [DATA_W-1:0]      data_q;
  logic                   valid_q;
  logic                   error_q;
  logic [7:0]             count_q;

  logic sck_s;
  logic sda_s;
  logic sck_rise;
  logic timeout;

  assign sck_s    = sck_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~prev_sck;
  // An sck rise always wins over the idle threshold on the same cycle.
  assign timeout  = (TIMEOUT_CYCLES != 0) && !sck_rise && (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_sync <= '1;
      sda_sync <= '0;
      prev_sck <= 1'b1;
      state    <= HUNT;
      zero_cnt <= '0;
      bit_idx  <= '0;
      led_idx  <= '0;
      idle_cnt <= '0;
      shadow   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], bus.sck};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda};
      prev_sck <= sck_s;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;

      if (sck_rise)
        idle_cnt <= '0;
      else if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + 1'b1;

      if (sck_rise) begin
        case (state)
          HUNT: begin
            if (!sda_s) begin
              if (zero_cnt != 6'd32) zero_cnt <= zero_cnt + 6'd1;
            end else if (zero_cnt == 6'd32) begin
              state    <= LED;
              bit_idx  <= 5'd1;
              led_idx  <= '0;
              zero_cnt <= '0;
            end else begin
              zero_cnt <= '0;
            end
          end
          LED: begin
            if (bit_idx <= 5'd2 && !sda_s) begin
              error_q  <= 1'b1;
              state    <= HUNT;
              zero_cnt <= '0;
              bit_idx  <= '0;
              led_idx  <= '0;
            end else begin
              if (bit_idx >= FIRST_DATA_BIT)
                shadow <= {shadow[DATA_W-2:0], sda_s};
              if (bit_idx == 5'd31) begin
                bit_idx <= '0;
                if (led_idx == LAST_LED) begin
                  data_q   <= {shadow[DATA_W-2:0], sda_s};
                  valid_q  <= 1'b1;
                  count_q  <= count_q + 8'd1;
                  state    <= HUNT;
                  zero_cnt <= '0;
                  led_idx  <= '0;
                end else begin
                  led_idx <= led_idx + 6'd1;
                end
              end else begin
                bit_idx <= bit_idx + 5'd1;
              end
            end
          end
          default: state <= HUNT;
        endcase
      end else if (timeout) begin
        // Abort a partial frame loudly; a partial start run is dropped silently.
        if (state == LED) begin
          error_q <= 1'b1;
          state   <= HUNT;
          bit_idx <= '0;
          led_idx <= '0;
        end
        zero_cnt <= '0;
      end
    end
  end

  assign bus.data_out    = data_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_error = error_q;
  assign bus.busy        = (state == LED);
  assign bus.frame_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_apa102_rx_chain.sv
`default_nettype none
// tb_apa102_rx_chain: directed checks of the APA102 receiver in three configurations.
// Rev 1.0
module tb_apa102_rx_chain;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sck = 1'b1;
  logic sda = 1'b0;
  int   sel = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  // a: defaults; b: two LEDs with brightness, no timeout; c: four LEDs, 64-cycle timeout
  apa102_rx_chain_if #(.NUM_LEDS(7), .KEEP_BRIGHTNESS(0)) bus_a ();
  apa102_rx_chain_if #(.NUM_LEDS(2), .KEEP_BRIGHTNESS(1)) bus_b ();
  apa102_rx_chain_if #(.NUM_LEDS(4), .KEEP_BRIGHTNESS(0)) bus_c ();

  assign bus_a.sck = (sel == 0) ? sck : 1'b1;
  assign bus_a.sda = (sel == 0) ? sda : 1'b0;
  assign bus_b.sck = (sel == 1) ? sck : 1'b1;
  assign bus_b.sda = (sel == 1) ? sda : 1'b0;
  assign bus_c.sck = (sel == 2) ? sck : 1'b1;
  assign bus_c.sda = (sel == 2) ? sda : 1'b0;

  apa102_rx_chain #(.NUM_LEDS(7), .KEEP_BRIGHTNESS(0), .SYNC_STAGES(2), .TIMEOUT_CYCLES(4096))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  apa102_rx_chain #(.NUM_LEDS(2), .KEEP_BRIGHTNESS(1), .SYNC_STAGES(2), .TIMEOUT_CYCLES(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  apa102_rx_chain #(.NUM_LEDS(4), .KEEP_BRIGHTNESS(0), .SYNC_STAGES(3), .TIMEOUT_CYCLES(64))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  int fv_a = 0, fe_a = 0, bz_a = 0;
  int fv_b = 0, fe_b = 0;
  int fv_c = 0, fe_c = 0;
  int both = 0;

  always @(negedge clk) begin
    if (bus_a.frame_valid) fv_a++;
    if (bus_a.frame_error) fe_a++;
    if (bus_a.busy)        bz_a++;
    if (bus_b.frame_valid) fv_b++;
    if (bus_b.frame_error) fe_b++;
    if (bus_c.frame_valid) fv_c++;
    if (bus_c.frame_error) fe_c++;
    if ((bus_a.frame_valid && bus_a.frame_error) || (bus_b.frame_valid && bus_b.frame_error) ||
        (bus_c.frame_valid && bus_c.frame_error))
      both++;
  end

  task automatic send_bit(input logic b);
    sda = b;
    sck = 1'b0;
    repeat (4) @(posedge clk);
    sck = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input int nbits);
    for (int i = 31; i > 31 - nbits; i--) send_bit(w[i]);
  endtask

  task automatic send_run(input logic b, input int n);
    for (int i = 0; i < n; i++) send_bit(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    sel = 0;
    do_reset();
    @(negedge clk);
    total++; if (bus_a.data_out !== '0) begin bad++; $display("FAIL reset_data_a got=%h want=0", bus_a.data_out); end
    total++; if (bus_a.frame_count !== 8'd0) begin bad++; $display("FAIL reset_count_a got=%0d want=0", bus_a.frame_count); end
    total++; if ({bus_a.busy, bus_a.frame_valid, bus_a.frame_error} !== 3'b000) begin bad++; $display("FAIL reset_flags_a got=%b want=000", {bus_a.busy, bus_a.frame_valid, bus_a.frame_error}); end
    total++; if (bus_b.data_out !== '0) begin bad++; $display("FAIL reset_data_b got=%h want=0", bus_b.data_out); end
    total++; if (bus_c.data_out !== '0 || bus_c.busy !== 1'b0) begin bad++; $display("FAIL reset_c got=%h/%b want=0/0", bus_c.data_out, bus_c.busy); end
  endtask

  task automatic send_default_frame(input int zeros);
    send_run(1'b0, zeros);
    for (int n = 0; n < 7; n++) send_word(32'hE011_2233 + 32'(n), 32);
    send_run(1'b1, 32);
  endtask

  task automatic test_default_frame();
    int v0, e0;
    sel = 0; v0 = fv_a; e0 = fe_a;
    send_default_frame(32);
    @(negedge clk);
    total++; if (fv_a - v0 !== 1) begin bad++; $display("FAIL s1_valid_pulses got=%0d want=1", fv_a - v0); end
    total++; if (fe_a - e0 !== 0) begin bad++; $display("FAIL s1_error_pulses got=%0d want=0", fe_a - e0); end
    total++; if (bus_a.data_out[167:144] !== 24'h112233) begin bad++; $display("FAIL s1_led0 got=%h want=112233", bus_a.data_out[167:144]); end
    total++; if (bus_a.data_out[95:72] !== 24'h112236) begin bad++; $display("FAIL s1_led3 got=%h want=112236", bus_a.data_out[95:72]); end
    total++; if (bus_a.data_out[23:0] !== 24'h112239) begin bad++; $display("FAIL s1_led6 got=%h want=112239", bus_a.data_out[23:0]); end
    total++; if (bus_a.frame_count !== 8'd1) begin bad++; $display("FAIL s1_count got=%0d want=1", bus_a.frame_count); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL s1_busy got=%b want=0", bus_a.busy); end
  endtask

  task automatic test_header_error();
    int v0, e0;
    sel = 0; v0 = fv_a; e0 = fe_a;
    send_run(1'b0, 32);
    send_word(32'hA0FF_FFFF, 32);
    send_run(1'b1, 32);
    @(negedge clk);
    total++; if (fe_a - e0 !== 1) begin bad++; $display("FAIL s3_error_pulses got=%0d want=1", fe_a - e0); end
    total++; if (fv_a - v0 !== 0) begin bad++; $display("FAIL s3_valid_pulses got=%0d want=0", fv_a - v0); end
    total++; if (bus_a.data_out[167:144] !== 24'h112233 || bus_a.data_out[23:0] !== 24'h112239) begin bad++; $display("FAIL s3_data_held got=%h want=112233..112239", bus_a.data_out); end
    total++; if (bus_a.frame_count !== 8'd1) begin bad++; $display("FAIL s3_count got=%0d want=1", bus_a.frame_count); end
  endtask

  task automatic test_long_start();
    int v0;
    sel = 0; v0 = fv_a;
    send_default_frame(40);
    @(negedge clk);
    total++; if (fv_a - v0 !== 1) begin bad++; $display("FAIL s4_valid_pulses got=%0d want=1", fv_a - v0); end
    total++; if (bus_a.frame_count !== 8'd2) begin bad++; $display("FAIL s4_count got=%0d want=2", bus_a.frame_count); end
    total++; if (bus_a.data_out[167:144] !== 24'h112233 || bus_a.data_out[23:0] !== 24'h112239) begin bad++; $display("FAIL s4_data got=%h want=112233..112239", bus_a.data_out); end
  endtask

  task automatic test_brightness();
    int v0;
    sel = 1; v0 = fv_b;
    send_run(1'b0, 32);
    send_word(32'hFFAB_CDEF, 32);
    send_word(32'hE101_0203, 32);
    send_run(1'b1, 32);
    @(negedge clk);
    total++; if (bus_b.data_out !== {5'h1F, 24'hABCDEF, 5'h01, 24'h010203}) begin bad++; $display("FAIL s2_data got=%h want=%h", bus_b.data_out, {5'h1F, 24'hABCDEF, 5'h01, 24'h010203}); end
    total++; if (fv_b - v0 !== 1) begin bad++; $display("FAIL s2_valid_pulses got=%0d want=1", fv_b - v0); end
    total++; if (bus_b.frame_count !== 8'd1) begin bad++; $display("FAIL s2_count got=%0d want=1", bus_b.frame_count); end
  endtask

  task automatic test_timeout();
    int v0, e0;
    sel = 2; v0 = fv_c; e0 = fe_c;
    send_run(1'b0, 32);
    for (int n = 0; n < 3; n++) send_word(32'hE0AA_BB00 + 32'(n), 32);
    send_word(32'hE0AA_BBCC, 10);
    @(negedge clk);
    total++; if (bus_c.busy !== 1'b1) begin bad++; $display("FAIL s5_busy_mid got=%b want=1", bus_c.busy); end
    repeat (100) @(posedge clk);
    @(negedge clk);
    total++; if (fe_c - e0 !== 1) begin bad++; $display("FAIL s5_error_pulses got=%0d want=1", fe_c - e0); end
    total++; if (bus_c.busy !== 1'b0) begin bad++; $display("FAIL s5_busy_after got=%b want=0", bus_c.busy); end
    total++; if (bus_c.data_out !== '0 || fv_c - v0 !== 0) begin bad++; $display("FAIL s5_no_commit got=%h/%0d want=0/0", bus_c.data_out, fv_c - v0); end
    send_run(1'b0, 32);
    for (int n = 1; n <= 4; n++) send_word(32'hE000_0000 + 32'(n), 32);
    send_run(1'b1, 32);
    @(negedge clk);
    total++; if (bus_c.data_out !== {24'h000001, 24'h000002, 24'h000003, 24'h000004}) begin bad++; $display("FAIL s5_recover_data got=%h want=000001000002000003000004", bus_c.data_out); end
    total++; if (fv_c - v0 !== 1 || bus_c.frame_count !== 8'd1) begin bad++; $display("FAIL s5_recover_count got=%0d/%0d want=1/1", fv_c - v0, bus_c.frame_count); end
  endtask

  task automatic test_reset_sck_high();
    int v0, e0, b0;
    sel = 0; sck = 1'b1;
    do_reset();
    v0 = fv_a; e0 = fe_a; b0 = bz_a;
    send_run(1'b0, 31); send_bit(1'b1);
    send_run(1'b0, 31); send_bit(1'b1);
    @(negedge clk);
    total++; if (bz_a - b0 !== 0) begin bad++; $display("FAIL s6_busy_cycles got=%0d want=0", bz_a - b0); end
    total++; if (fv_a - v0 !== 0 || fe_a - e0 !== 0) begin bad++; $display("FAIL s6_pulses got=%0d/%0d want=0/0", fv_a - v0, fe_a - e0); end
  endtask

  task automatic test_reset_mid_frame();
    sel = 0;
    send_default_frame(32);
    send_run(1'b0, 32);
    send_word(32'hE011_2233, 12);
    @(negedge clk);
    total++; if (bus_a.busy !== 1'b1 || bus_a.frame_count !== 8'd1) begin bad++; $display("FAIL s6_pre_reset got=%b/%0d want=1/1", bus_a.busy, bus_a.frame_count); end
    do_reset();
    @(negedge clk);
    total++; if (bus_a.data_out !== '0 || bus_a.frame_count !== 8'd0) begin bad++; $display("FAIL s6_mid_reset_data got=%h/%0d want=0/0", bus_a.data_out, bus_a.frame_count); end
    total++; if ({bus_a.busy, bus_a.frame_valid, bus_a.frame_error} !== 3'b000) begin bad++; $display("FAIL s6_mid_reset_flags got=%b want=000", {bus_a.busy, bus_a.frame_valid, bus_a.frame_error}); end
  endtask

  initial begin
    test_reset();
    test_default_frame();
    test_header_error();
    test_long_start();
    test_brightness();
    test_timeout();
    test_reset_sck_high();
    test_reset_mid_frame();
    total++; if (both !== 0) begin bad++; $display("FAIL valid_error_overlap got=%0d want=0", both); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
